// File: rtl/des_ip_loader.sv
// des_ip_loader: DES input stage. Collects a 64-bit block from a byte-serial
// valid/ready stream, applies the Initial Permutation (IP) and offers the
// registered halves L0/R0 to the round engine via a valid/ready handshake.
//
// Parameter MSB_FIRST: 1 = first byte carries DES bits 1..8, 0 = first byte
// carries DES bits 57..64.
// Optional macro DES_IP_SELFCHECK_EN: adds rIpErr, a sticky flag raised when
// the inverse permutation of the held L0/R0 disagrees with the assembled block.
//
// Ports:
//   wClk, wRstN         clock, asynchronous active-low reset
//   wClear              synchronous abort of the partial/held block
//   wInByte, wInValid   byte stream in; rInReady back-pressures it
//   rL0, rR0            IP output, rL0[n] = IP bit n, rR0[n] = IP bit 32+n
//   rOutValid/wOutReady output handshake
//   rByteCnt            bytes captured in the current block
//   rIpErr              (DES_IP_SELFCHECK_EN only) self-check error, sticky

module des_ip_loader #(
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic        wClk,
    input  logic        wRstN,
    input  logic        wClear,
    input  logic [7:0]  wInByte,
    input  logic        wInValid,
    output logic        rInReady,
    output logic [32:1] rL0,
    output logic [32:1] rR0,
    output logic        rOutValid,
    input  logic        wOutReady,
    output logic [2:0]  rByteCnt
`ifdef DES_IP_SELFCHECK_EN
    ,
    output logic        rIpErr
`endif
);

    localparam int unsigned BLK_W = 64;

    // Output bit i (1-based) takes input bit IP_TAB[i-1]; block vectors use [n] = DES bit n.
    localparam logic [6:0] IP_TAB [BLK_W] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    // COLLECT: accept bytes; MERGE: last captured byte lands in the block;
    // PERM: register IP result; HOLD: wait for the round engine.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MERGE   = 2'd1,
        PERM    = 2'd2,
        HOLD    = 2'd3
    } state_e;

    function automatic logic [64:1] ip_perm(input logic [64:1] blk);
        logic [64:1] res;
        res = '0;
        for (int unsigned i = 0; i < BLK_W; i++) begin
            res[7'(i + 1)] = blk[IP_TAB[6'(i)]];
        end
        return res;
    endfunction

    state_e      state_q, state_d;
    logic [64:1] asm_q, asm_d;
    logic [7:0]  byte_q, byte_d;
    logic [2:0]  oct_q, oct_d;
    logic        wr_q, wr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [32:1] l0_q, l0_d;
    logic [32:1] r0_q, r0_d;
    logic        ov_q, ov_d;
    logic        rdy_q, rdy_d;
    logic [64:1] ip_c;

    assign ip_c = ip_perm(asm_q);

`ifdef DES_IP_SELFCHECK_EN
    logic        err_q, err_d;
    logic [64:1] held_ip_c;
    logic [64:1] fp_c;

    // Final permutation undoes IP: DES bit IP_TAB[i] comes back from IP bit i+1.
    assign held_ip_c = {r0_q, l0_q};
    always_comb begin
        fp_c = '0;
        for (int unsigned i = 0; i < BLK_W; i++) begin
            fp_c[IP_TAB[6'(i)]] = held_ip_c[7'(i + 1)];
        end
    end

    always_comb begin
        err_d = err_q;
        if (wClear) begin
            err_d = 1'b0;
        end else if (state_q == HOLD && fp_c != asm_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rIpErr = err_q;
`endif

    // Next-state and datapath update; wClear overrides everything.
    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        byte_d  = byte_q;
        oct_d   = oct_q;
        wr_d    = 1'b0;
        cnt_d   = cnt_q;
        l0_d    = l0_q;
        r0_d    = r0_q;
        ov_d    = ov_q;
        rdy_d   = rdy_q;

        // Accepted bytes are registered first and written into their octet a cycle later.
        if (wr_q) begin
            for (int unsigned j = 0; j < 8; j++) begin
                asm_d[7'(8 * 32'(oct_q) + 1 + j)] = byte_q[3'(7 - j)];
            end
        end

        if (wClear) begin
            state_d = COLLECT;
            asm_d   = '0;
            cnt_d   = 3'd0;
            ov_d    = 1'b0;
            rdy_d   = 1'b1;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (wInValid && rdy_q) begin
                        byte_d = wInByte;
                        oct_d  = (MSB_FIRST != 0) ? cnt_q : 3'd7 - cnt_q;
                        wr_d   = 1'b1;
                        cnt_d  = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = MERGE;
                            rdy_d   = 1'b0;
                        end
                    end
                end
                MERGE: begin
                    state_d = PERM;
                end
                PERM: begin
                    l0_d    = ip_c[32:1];
                    r0_d    = ip_c[64:33];
                    ov_d    = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (wOutReady && ov_q) begin
                        ov_d    = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = COLLECT;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    rdy_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            state_q <= COLLECT;
            asm_q   <= '0;
            byte_q  <= '0;
            oct_q   <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            l0_q    <= '0;
            r0_q    <= '0;
            ov_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            byte_q  <= byte_d;
            oct_q   <= oct_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            l0_q    <= l0_d;
            r0_q    <= r0_d;
            ov_q    <= ov_d;
            rdy_q   <= rdy_d;
        end
    end

    assign rInReady  = rdy_q;
    assign rL0       = l0_q;
    assign rR0       = r0_q;
    assign rOutValid = ov_q;
    assign rByteCnt  = cnt_q;

endmodule

// File: tb/tb_des_ip_loader.sv
// Bench for des_ip_loader: two instances (MSB_FIRST=1 and 0) share one byte
// stream. A block-level model computes the expected L0/R0 for each instance;
// hand-written FIPS-notation constants pin the known vectors.

module tb_des_ip_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        out_ready;
    logic        rdy0, ov0, rdy1, ov1;
    logic [32:1] l0_0, r0_0, l0_1, r0_1;
    logic [2:0]  cnt0, cnt1;
`ifdef DES_IP_SELFCHECK_EN
    logic        err0, err1;
    logic [32:1] forced_l0;
`endif

    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;
    logic [63:0] exp0, exp1;
    logic [63:0] saved;
    logic [7:0]  blk [8];

    int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                      57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    always #5 clk = ~clk;

    des_ip_loader #(.MSB_FIRST(1)) u0 (
        .wClk(clk), .wRstN(rst_n), .wClear(clr), .wInByte(in_byte), .wInValid(in_valid),
        .rInReady(rdy0), .rL0(l0_0), .rR0(r0_0), .rOutValid(ov0), .wOutReady(out_ready),
        .rByteCnt(cnt0)
`ifdef DES_IP_SELFCHECK_EN
        , .rIpErr(err0)
`endif
    );

    des_ip_loader #(.MSB_FIRST(0)) u1 (
        .wClk(clk), .wRstN(rst_n), .wClear(clr), .wInByte(in_byte), .wInValid(in_valid),
        .rInReady(rdy1), .rL0(l0_1), .rR0(r0_1), .rOutValid(ov1), .wOutReady(out_ready),
        .rByteCnt(cnt1)
`ifdef DES_IP_SELFCHECK_EN
        , .rIpErr(err1)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // FIPS hex (leftmost = bit 1) to port layout where vec[n] = bit n.
    function automatic logic [32:1] from_fips(input logic [31:0] h);
        logic [32:1] r;
        for (int n = 1; n <= 32; n++) r[n] = h[32 - n];
        return r;
    endfunction

    // Block-level model: bytes -> DES bit array -> IP -> {L0, R0} in port layout.
    function automatic logic [63:0] model(input logic [7:0] b [8], input bit msb);
        bit          des [1:64];
        logic [32:1] l, r;
        for (int k = 0; k < 8; k++) begin
            int o;
            o = msb ? k : 7 - k;
            for (int j = 0; j < 8; j++) des[8 * o + 1 + j] = b[k][7 - j];
        end
        for (int i = 1; i <= 32; i++) begin
            l[i] = des[IP_T[i - 1]];
            r[i] = des[IP_T[32 + i - 1]];
        end
        return {l, r};
    endfunction

    // Whenever an output block is offered it must equal the model's block.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (ov0) chk("u0_l0r0", {l0_0, r0_0}, exp0);
            if (ov1) chk("u1_l0r0", {l0_1, r0_1}, exp1);
            chk("u0_ready_and_valid", 64'(ov0 & rdy0), 64'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the last accept edge.
    task automatic send(input logic [7:0] b [8], input int n);
        if (n == 8) begin
            exp0 = model(b, 1'b1);
            exp1 = model(b, 1'b0);
        end
        for (int k = 0; k < n; k++) begin
            int w;
            in_byte  = b[k];
            in_valid = 1'b1;
            w = 0;
            while (!rdy0 && w < 40) begin
                tick();
                w++;
            end
            if (!rdy0) chk("accept_timeout", 64'd1, 64'd0);
            tick();
            chk("u0_byte_cnt", 64'(cnt0), 64'((k + 1) % 8));
            chk("u1_byte_cnt", 64'(cnt1), 64'((k + 1) % 8));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int w;
        w = 0;
        while (!ov0 && w < 20) begin
            tick();
            w++;
        end
        if (!ov0) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        exp0 = '0; exp1 = '0;
        repeat (2) tick();
        chk("rst_ready", 64'(rdy0), 64'd1);
        chk("rst_valid", 64'(ov0), 64'd0);
        chk("rst_l0r0", {l0_0, r0_0}, 64'd0);
        chk("rst_cnt", 64'(cnt0), 64'd0);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // Known vector, latency and back-to-back acceptance.
        out_ready = 1'b1;
        blk = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        send(blk, 8);                                  // after accept edge t
        chk("lat_t_valid", 64'(ov0), 64'd0);
        chk("lat_t_ready", 64'(rdy0), 64'd0);
        tick();                                        // after t+1
        chk("lat_t1_valid", 64'(ov0), 64'd0);
        tick();                                        // after t+2
        chk("lat_t2_valid", 64'(ov0), 64'd1);
        chk("lat_t2_ready", 64'(rdy0), 64'd0);
        chk("u0_L0_lit", 64'(l0_0), 64'(from_fips(32'hCC00CCFF)));
        chk("u0_R0_lit", 64'(r0_0), 64'(from_fips(32'hF0AAF0AA)));
        tick();                                        // handshake at t+3
        chk("hs_valid_low", 64'(ov0), 64'd0);
        chk("hs_ready_high", 64'(rdy0), 64'd1);

        // Reversed byte order, also the first byte one cycle after handshake.
        blk = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        send(blk, 8);
        wait_ov();
        chk("u1_L0_lit", 64'(l0_1), 64'(from_fips(32'hCC00CCFF)));
        chk("u1_R0_lit", 64'(r0_1), 64'(from_fips(32'hF0AAF0AA)));
        tick();

        // Only DES bit 1 set: lands in IP bit 40 (R0 bit 8).
        blk = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(blk, 8);
        wait_ov();
        chk("bit1_L0", 64'(l0_0), 64'(from_fips(32'h00000000)));
        chk("bit1_R0", 64'(r0_0), 64'(from_fips(32'h01000000)));
        tick();

        // Back-pressure: held block, pending byte not consumed.
        out_ready = 1'b0;
        blk = '{8'h13, 8'h34, 8'h57, 8'h79, 8'h9B, 8'hBC, 8'hDF, 8'hF1};
        send(blk, 8);
        wait_ov();
        saved    = {l0_0, r0_0};
        in_byte  = 8'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_ready", 64'(rdy0), 64'd0);
            chk("bp_valid", 64'(ov0), 64'd1);
            chk("bp_cnt", 64'(cnt0), 64'd0);
            chk("bp_stable", {l0_0, r0_0}, saved);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 64'(ov0), 64'd0);
        chk("bp_hs_cnt", 64'(cnt0), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("bp_one_hs", 64'(ov0), 64'd0);
        chk("bp_no_extra", 64'(cnt0), 64'd0);

        // Abort after 5 bytes, then a clean all-zero block.
        blk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h11, 8'h22, 8'h33};
        send(blk, 5);
        clr      = 1'b1;
        in_byte  = 8'hFF;
        in_valid = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", 64'(cnt0), 64'd0);
        chk("clr_valid", 64'(ov0), 64'd0);
        chk("clr_ready", 64'(rdy0), 64'd1);
        chk("clr_keep_l0r0", {l0_0, r0_0}, saved);
        tick();
        chk("clr_byte_dropped", 64'(cnt0), 64'd0);
        blk = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(blk, 8);
        wait_ov();
        chk("zero_u0", {l0_0, r0_0}, 64'd0);
        chk("zero_u1", {l0_1, r0_1}, 64'd0);
        tick();

`ifdef DES_IP_SELFCHECK_EN
        // Corrupt the held L0 and expect the sticky error flag.
        out_ready = 1'b0;
        blk = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        send(blk, 8);
        wait_ov();
        tick();
        chk("selfchk_clean", 64'(err0), 64'd0);
        chk_en    = 1'b0;
        forced_l0 = l0_0 ^ 32'h1;
        force u0.l0_q = forced_l0;
        tick();
        tick();
        chk("selfchk_err", 64'(err0), 64'd1);
        release u0.l0_q;
        tick();
        chk("selfchk_sticky", 64'(err0), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("selfchk_clr", 64'(err0), 64'd0);
        chk_en    = 1'b1;
        out_ready = 1'b1;
        tick();
`endif

        // Asynchronous reset while holding a block.
        out_ready = 1'b0;
        blk = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
        send(blk, 8);
        wait_ov();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ov0), 64'd0);
        chk("arst_ready", 64'(rdy0), 64'd1);
        chk("arst_l0r0", {l0_0, r0_0}, 64'd0);
        chk("arst_cnt", 64'(cnt0), 64'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();

        // Recovery block after reset.
        blk = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
        send(blk, 8);
        wait_ov();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
